// File: rtl/alu_pipe_flags_if.sv
// Handshake and operand/result bundle between the bus mux, the ALU and the controller.
// master: drives start/sel/data_1/data_2; slave (the ALU): drives results, flags, busy, done.
interface alu_pipe_flags_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       sel;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] ALU_out;
    logic [WIDTH-1:0] ALU_hi;
    logic             ALU_Zflag;
    logic             ALU_Cflag;
    logic             ALU_Nflag;
    logic             ALU_Vflag;
    logic             busy;
    logic             done;

    modport master (
        output start, sel, data_1, data_2,
        input  ALU_out, ALU_hi, ALU_Zflag, ALU_Cflag,
        input  ALU_Nflag, ALU_Vflag, busy, done
    );

    modport slave (
        input  start, sel, data_1, data_2,
        output ALU_out, ALU_hi, ALU_Zflag, ALU_Cflag,
        output ALU_Nflag, ALU_Vflag, busy, done
    );
endinterface

// File: rtl/alu_pipe_flags.sv
// Registered ALU with Z/C/N/V flags, start/busy/done handshake and iterative multiplier.
// Ports: clk, rst (sync, active-high), bus (slave: start/sel/data_1/data_2 in; results, flags, busy, done out).
module alu_pipe_flags #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    alu_pipe_flags_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int M   = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_z;
    logic               r_c;
    logic               r_n;
    logic               r_v;
    logic               r_done;

    logic               w_is_mul;
    logic               w_go_single;
    logic               w_go_mul;
    logic               w_mul_last;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_wide;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_nop;
    logic [WIDTH:0]     w_step;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_sh     = bus.data_1[SHW-1:0];
    assign w_is_mul = MUL_EN && (bus.sel == OP_MUL);

    // Single-cycle datapath. Shifts run through a WIDTH+1 bit window so
    // the extra bit is the last bit shifted out (zero for amount 0).
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_nop  = 1'b0;
        unique case (1'b1)
            (bus.sel == OP_ADD): begin
                w_wide = {1'b0, bus.data_2} + {1'b0, bus.data_1};
                w_res  = w_wide[M:0];
                w_c    = w_wide[WIDTH];
                w_v    = (bus.data_2[M] == bus.data_1[M]) &&
                         (w_res[M] != bus.data_2[M]);
            end
            (bus.sel == OP_SUB): begin
                w_wide = {1'b0, bus.data_2} - {1'b0, bus.data_1};
                w_res  = w_wide[M:0];
                w_c    = w_wide[WIDTH];
                w_v    = (bus.data_2[M] != bus.data_1[M]) &&
                         (w_res[M] != bus.data_2[M]);
            end
            (bus.sel == OP_AND): w_res = bus.data_2 & bus.data_1;
            (bus.sel == OP_NOT): w_res = ~bus.data_2;
            (bus.sel == OP_OR):  w_res = bus.data_2 | bus.data_1;
            (bus.sel == OP_XOR): w_res = bus.data_2 ^ bus.data_1;
            (bus.sel == OP_SHL): begin
                w_wide = {1'b0, bus.data_2} << w_sh;
                w_res  = w_wide[M:0];
                w_c    = w_wide[WIDTH];
            end
            (bus.sel == OP_SHR): begin
                w_wide = {bus.data_2, 1'b0} >> w_sh;
                w_res  = w_wide[WIDTH:1];
                w_c    = w_wide[0];
            end
            default: w_nop = 1'b1;
        endcase
    end

    // Shift-add step: r_acc holds {partial high, remaining multiplier bits}.
    assign w_step    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_step, r_acc[M:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_go_single = 1'b0;
        w_go_mul    = 1'b0;
        w_mul_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_is_mul) begin
                        w_go_mul    = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_go_single = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_hi    <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_go_single) begin
                r_done <= 1'b1;
                r_out  <= w_res;
                r_hi   <= '0;
                if (!w_nop) begin
                    r_z <= (w_res == '0);
                    r_c <= w_c;
                    r_n <= w_res[M];
                    r_v <= w_v;
                end
            end
            if (w_go_mul) begin
                r_acc   <= {{WIDTH{1'b0}}, bus.data_1};
                r_mcand <= bus.data_2;
                r_cnt   <= CW'(WIDTH);
            end
            if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_mul_last) begin
                r_done <= 1'b1;
                r_out  <= w_acc_nxt[M:0];
                r_hi   <= w_acc_nxt[2*WIDTH-1:WIDTH];
                r_z    <= (w_acc_nxt[M:0] == '0);
                r_c    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_n    <= w_acc_nxt[M];
                r_v    <= 1'b0;
            end
        end
    end

    assign bus.ALU_out   = r_out;
    assign bus.ALU_hi    = r_hi;
    assign bus.ALU_Zflag = r_z;
    assign bus.ALU_Cflag = r_c;
    assign bus.ALU_Nflag = r_n;
    assign bus.ALU_Vflag = r_v;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = r_done;
endmodule
